mult_norm_round: RTL and testbench
==================================

Name: mult_norm_round

Overview:
- Downstream consumer of the Booth/Dadda mantissa multiplier in the CVFPU FP16 multiply path.
- Takes the raw 2*MANT_W-bit mantissa product, the pre-computed biased exponent sum and the result sign.
- Normalises, rounds (RNE by default) and adjusts the exponent.
- Flags overflow/underflow through a 2-stage valid/ready pipeline that absorbs backpressure from the FPU writeback.

Parameters:
- MANT_W, 11, mantissa width including hidden bit; equals multiplier operand width.
- EXP_W, 5, biased exponent width of the result format.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- in_valid_i  input  1  product/exponent/sign valid
- in_ready_o  output  1  block can accept input this cycle
- prod_i  input  2*MANT_W  unsigned multiplier output
- exp_sum_i  input  EXP_W+2  signed two's-complement biased sum, e_a+e_b-bias
- sign_i  input  1  result sign, sign_a XOR sign_b
- out_valid_o  output  1  result valid
- out_ready_i  input  1  downstream accepts result
- mant_o  output  MANT_W  rounded normalised mantissa incl. hidden bit
- exp_o  output  EXP_W  result biased exponent
- sign_o  output  1  result sign
- ovf_o  output  1  exponent overflow; result forced to infinity
- uf_o  output  1  exponent underflow; result flushed to zero

Behaviour:
- Reset (sync, rst=1 at posedge): both stage valids cleared.
  - All outputs reset to 0: out_valid_o=0, mant_o=0, exp_o=0, sign_o=0, ovf_o=0, uf_o=0.
  - in_ready_o=1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight data; no partial output is ever produced.
- Handshake:
  - Transfer on valid&ready.
  - Stage k advances when it is empty or stage k+1 advances. Stage 2 advances when out_ready_i=1 or it is empty.
  - in_ready_o = !s1_valid | s1_advance (combinational from out_ready_i through the chain).
  - Outputs hold stable while out_valid_o=1 and out_ready_i=0.
- Latency and throughput: 2 cycles from input transfer to out_valid_o with no backpressure; 1 result/cycle sustained; order preserved; max 2 in flight.
- Stage 1, normalise (registered). Let P = prod_i, N = 2*MANT_W.
  - If P[N-1]=1: m=P[N-1:MANT_W], g=P[MANT_W-1], s=|P[MANT_W-2:0], e=exp_sum_i+1.
  - Else: m=P[N-2:MANT_W-1], g=P[MANT_W-2], s=|P[MANT_W-3:0], e=exp_sum_i.
  - P==0: zero flag set; it propagates to stage 2.
- Stage 2, round/adjust (registered outputs).
  - RNE: inc = g & (s | m[0]).
  - m+inc computed at MANT_W+1 bits. On carry-out, mant = 1 followed by zeros (2^(MANT_W-1)) and e = e+1.
  - Exponent arithmetic uses EXP_W+2 signed bits throughout; no intermediate wrap.
- Final classification, priority zero > ovf > uf > normal:
  - zero: mant_o=0, exp_o=0, no flags.
  - e >= 2^EXP_W-1: ovf_o=1, exp_o=all ones, mant_o=0.
  - e <= 0: uf_o=1, exp_o=0, mant_o=0 (flush-to-zero; no subnormals).
  - else: exp_o=e[EXP_W-1:0].
  - sign_o is always passed through, including for zero, inf and flush.
- Simultaneous input accept and output accept in the same cycle with both stages full: allowed, no bubble.

Optional Feature:
- Macro: MULT_NORM_RMODE_EN.
- Defined:
  - Adds port rm_i (input, 2 bits), sampled with the input transfer and piped alongside the data.
  - Encodings: 00 RNE, 01 RTZ (inc=0), 10 RDN (inc=(g|s)&sign), 11 RUP (inc=(g|s)&!sign).
  - Overflow under RTZ, RDN with sign=0, or RUP with sign=1 saturates to max finite: exp=2^EXP_W-2, mant all ones, ovf_o=1.
- Undefined: no rm_i port; RNE only; overflow always gives infinity.

Test Plan:
- Reset then prod_i=22'h100000, exp_sum_i=15, sign=0, out_ready=1 -> 2 cycles later mant_o=11'h400, exp_o=15, no flags.
- prod_i=22'h200000, exp_sum_i=15 -> mant_o=11'h400, exp_o=16.
- Ties and round carry:
  - prod_i=22'h100200 (tie, lsb 0) -> mant_o=11'h400.
  - prod_i=22'h100600 (tie, lsb 1) -> mant_o=11'h402.
  - prod_i=22'h1FFE00, exp 15 -> mant_o=11'h400, exp_o=16 (carry renorm).
- Exponent limits and zero:
  - prod_i=22'h200000, exp_sum_i=30 -> ovf_o=1, exp_o=31, mant_o=0.
  - exp_sum_i=0, prod_i=22'h100000 -> uf_o=1, mant/exp=0.
  - prod_i=0 -> all-zero result, no flags.
- Backpressure: out_ready=0, 3 back-to-back inputs -> in_ready_o low after 2 accepted.
  - Release -> results delivered in order, 1/cycle, none lost or duplicated.
- Assert rst while 2 results are in flight -> next cycle out_valid_o=0, in_ready_o=1; no stale result after reset.

Source files
------------

// File: rtl/mult_norm_round.sv
// Normalise, round and exponent-adjust the raw mantissa product of the FP16 multiply path.
// Latency 2 cycles (normalise stage, round/classify stage); 1 result/cycle sustained.
// Backpressure: out_ready_i low stalls stage 2, then stage 1, then drops in_ready_o.
// Optional macro MULT_NORM_RMODE_EN adds rm_i (RNE/RTZ/RDN/RUP) with saturating overflow.
module mult_norm_round #(
   parameter int MANT_W = 11,
   parameter int EXP_W  = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [2*MANT_W-1:0]      prod_i,
   input  logic signed [EXP_W+1:0]  exp_sum_i,
   input  logic                     sign_i,
`ifdef MULT_NORM_RMODE_EN
   input  logic [1:0]               rm_i,
`endif
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [MANT_W-1:0]        mant_o,
   output logic [EXP_W-1:0]         exp_o,
   output logic                     sign_o,
   output logic                     ovf_o,
   output logic                     uf_o
);

   localparam int N  = 2 * MANT_W;
   localparam int EW = EXP_W + 2;
   localparam logic signed [EW-1:0] E_ONE  = EW'(1);
   localparam logic signed [EW-1:0] E_ZERO = '0;
   localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);

   // stage 1 state
   logic                 s1_vld_q;
   logic [MANT_W-1:0]    s1_m_q,    s1_m_d;
   logic                 s1_g_q,    s1_g_d;
   logic                 s1_s_q,    s1_s_d;
   logic signed [EW-1:0] s1_e_q,    s1_e_d;
   logic                 s1_zero_q, s1_zero_d;
   logic                 s1_sign_q;
`ifdef MULT_NORM_RMODE_EN
   logic [1:0]           s1_rm_q;
`endif

   // stage 2 (output) state
   logic                 s2_vld_q;
   logic [MANT_W-1:0]    mant_q, mant_d;
   logic [EXP_W-1:0]     exp_q,  exp_d;
   logic                 sign_q;
   logic                 ovf_q,  ovf_d;
   logic                 uf_q,   uf_d;

   logic s1_adv, s2_adv;

   // a stage moves when it is empty or its successor moves
   always_comb begin
      s2_adv     = !s2_vld_q || out_ready_i;
      s1_adv     = !s1_vld_q || s2_adv;
      in_ready_o = s1_adv;
   end

   // normalise: pick the 1x or 2x product window, split off guard and sticky
   always_comb begin
      s1_zero_d = (prod_i == '0);
      if (prod_i[N-1]) begin
         s1_m_d = prod_i[N-1:MANT_W];
         s1_g_d = prod_i[MANT_W-1];
         s1_s_d = |prod_i[MANT_W-2:0];
         s1_e_d = exp_sum_i + E_ONE;
      end else begin
         s1_m_d = prod_i[N-2:MANT_W-1];
         s1_g_d = prod_i[MANT_W-2];
         s1_s_d = |prod_i[MANT_W-3:0];
         s1_e_d = exp_sum_i;
      end
   end

   // stage 1 register: load a new operand whenever the stage is allowed to move
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q  <= 1'b0;
         s1_m_q    <= '0;
         s1_g_q    <= 1'b0;
         s1_s_q    <= 1'b0;
         s1_e_q    <= '0;
         s1_zero_q <= 1'b0;
         s1_sign_q <= 1'b0;
`ifdef MULT_NORM_RMODE_EN
         s1_rm_q   <= 2'b00;
`endif
      end else if (s1_adv) begin
         s1_vld_q <= in_valid_i;
         if (in_valid_i) begin
            s1_m_q    <= s1_m_d;
            s1_g_q    <= s1_g_d;
            s1_s_q    <= s1_s_d;
            s1_e_q    <= s1_e_d;
            s1_zero_q <= s1_zero_d;
            s1_sign_q <= sign_i;
`ifdef MULT_NORM_RMODE_EN
            s1_rm_q   <= rm_i;
`endif
         end
      end
   end

   logic                 inc;
   logic                 sat;
   logic [MANT_W:0]      sum;
   logic [MANT_W-1:0]    mant_rnd;
   logic signed [EW-1:0] e_rnd;

   // round, renormalise on carry-out, then classify zero > ovf > uf > normal
   always_comb begin
      inc = s1_g_q & (s1_s_q | s1_m_q[0]);
      sat = 1'b0;
`ifdef MULT_NORM_RMODE_EN
      case (s1_rm_q)
         2'b01:   inc = 1'b0;
         2'b10:   inc = (s1_g_q | s1_s_q) & s1_sign_q;
         2'b11:   inc = (s1_g_q | s1_s_q) & !s1_sign_q;
         default: inc = s1_g_q & (s1_s_q | s1_m_q[0]);
      endcase
      // modes that round away from infinity clamp to the largest finite value
      sat = (s1_rm_q == 2'b01) ||
            (s1_rm_q == 2'b10 && !s1_sign_q) ||
            (s1_rm_q == 2'b11 && s1_sign_q);
`endif
      sum = {1'b0, s1_m_q} + {{MANT_W{1'b0}}, inc};
      if (sum[MANT_W]) begin
         mant_rnd = {1'b1, {(MANT_W-1){1'b0}}};
         e_rnd    = s1_e_q + E_ONE;
      end else begin
         mant_rnd = sum[MANT_W-1:0];
         e_rnd    = s1_e_q;
      end

      mant_d = mant_rnd;
      exp_d  = e_rnd[EXP_W-1:0];
      ovf_d  = 1'b0;
      uf_d   = 1'b0;
      if (s1_zero_q) begin
         mant_d = '0;
         exp_d  = '0;
      end else if (e_rnd >= E_MAX) begin
         ovf_d = 1'b1;
         if (sat) begin
            mant_d = '1;
            exp_d  = {{(EXP_W-1){1'b1}}, 1'b0};
         end else begin
            mant_d = '0;
            exp_d  = '1;
         end
      end else if (e_rnd <= E_ZERO) begin
         uf_d   = 1'b1;
         mant_d = '0;
         exp_d  = '0;
      end
   end

   // stage 2 register: outputs hold while the consumer stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_vld_q <= 1'b0;
         mant_q   <= '0;
         exp_q    <= '0;
         sign_q   <= 1'b0;
         ovf_q    <= 1'b0;
         uf_q     <= 1'b0;
      end else if (s2_adv) begin
         s2_vld_q <= s1_vld_q;
         if (s1_vld_q) begin
            mant_q <= mant_d;
            exp_q  <= exp_d;
            sign_q <= s1_sign_q;
            ovf_q  <= ovf_d;
            uf_q   <= uf_d;
         end
      end
   end

   assign out_valid_o = s2_vld_q;
   assign mant_o      = mant_q;
   assign exp_o       = exp_q;
   assign sign_o      = sign_q;
   assign ovf_o       = ovf_q;
   assign uf_o        = uf_q;

endmodule

// File: tb/tb_mult_norm_round.sv
// Randomised and directed bench for mult_norm_round against an arithmetic reference model.
// Results are scoreboarded in acceptance order; held outputs are rechecked every stalled cycle.
// Backpressure and mid-flight reset are exercised explicitly.
module tb_mult_norm_round;

   logic              clk;
   logic              rst;
   logic              in_valid_i;
   logic              in_ready_o;
   logic [21:0]       prod_i;
   logic signed [6:0] exp_sum_i;
   logic              sign_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [10:0]       mant_o;
   logic [4:0]        exp_o;
   logic              sign_o;
   logic              ovf_o;
   logic              uf_o;

   int n_tests = 0;
   int n_fail  = 0;
   logic [18:0] exp_q[$];
   logic accepted;

   mult_norm_round #(.MANT_W(11), .EXP_W(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .prod_i(prod_i), .exp_sum_i(exp_sum_i), .sign_i(sign_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .mant_o(mant_o), .exp_o(exp_o), .sign_o(sign_o),
      .ovf_o(ovf_o), .uf_o(uf_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // Reference: value-level rounding of P to MANT_W significant bits, ties to even.
   function automatic logic [18:0] model(input logic [21:0] p, input int es, input logic sg);
      longint pl, m, rem, half;
      int sh, e;
      pl = longint'(p);
      if (pl == 0) return {11'd0, 5'd0, sg, 2'b00};
      if (pl >= 64'h200000) begin sh = 11; e = es + 1; end
      else begin sh = 10; e = es; end
      m    = pl >> sh;
      rem  = pl % (64'd1 << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && (m % 2) == 1)) m = m + 1;
      if (m == 2048) begin m = 1024; e = e + 1; end
      if (e >= 31) return {11'd0, 5'd31, sg, 2'b10};
      if (e <= 0)  return {11'd0, 5'd0, sg, 2'b01};
      return {m[10:0], e[4:0], sg, 2'b00};
   endfunction

   // one cycle: drive at negedge, observe just after, record the transfers of the next posedge
   task automatic step(input logic v, input logic [21:0] p, input int es, input logic sg,
                       input logic ordy);
      @(negedge clk);
      in_valid_i  = v;
      prod_i      = p;
      exp_sum_i   = es[6:0];
      sign_i      = sg;
      out_ready_i = ordy;
      #1;
      if (out_valid_o) begin
         if (exp_q.size() == 0) check("spurious_valid", 32'(out_valid_o), 32'd0);
         else begin
            check("result", 32'({mant_o, exp_o, sign_o, ovf_o, uf_o}), 32'(exp_q[0]));
            if (out_ready_i) void'(exp_q.pop_front());
         end
      end
      accepted = in_valid_i && in_ready_o;
      if (accepted) exp_q.push_back(model(p, es, sg));
   endtask

   task automatic send(input logic [21:0] p, input int es, input logic sg);
      int k = 0;
      do begin
         step(1'b1, p, es, sg, 1'b1);
         k++;
      end while (!accepted && k < 50);
      if (!accepted) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 20) begin
         step(1'b0, 22'd0, 0, 1'b0, 1'b1);
         k++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      step(1'b0, 22'd0, 0, 1'b0, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, b, es;
      logic [21:0] p;
      rst = 1'b1; in_valid_i = 1'b0; prod_i = '0; exp_sum_i = '0; sign_i = 1'b0;
      out_ready_i = 1'b1; accepted = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid_o), 32'd0);
      check("rst_in_ready", 32'(in_ready_o), 32'd1);
      check("rst_outputs", 32'({mant_o, exp_o, sign_o, ovf_o, uf_o}), 32'd0);

      // latency: visible two edges after the accepting edge
      step(1'b1, 22'h100000, 15, 1'b0, 1'b1);
      check("first_accept", 32'(accepted), 32'd1);
      step(1'b0, 22'd0, 0, 1'b0, 1'b1);
      check("latency_early", 32'(out_valid_o), 32'd0);
      step(1'b0, 22'd0, 0, 1'b0, 1'b1);
      check("latency_due", 32'(out_valid_o), 32'd1);
      check("first_mant", 32'(mant_o), 32'h400);
      check("first_exp", 32'(exp_o), 32'd15);
      drain();

      // directed normalise / round / limit cases, back to back
      send(22'h200000, 15, 1'b0);
      send(22'h100200, 15, 1'b1);
      send(22'h100600, 15, 1'b0);
      send(22'h1FFE00, 15, 1'b0);
      send(22'h200000, 30, 1'b1);
      send(22'h100000, 0,  1'b0);
      send(22'h000000, 20, 1'b1);
      send(22'h3FFFFF, 29, 1'b0);
      send(22'h155555, -3, 1'b1);
      drain();

      // backpressure: two accepted, third refused, then released without a bubble
      step(1'b1, 22'h123456, 10, 1'b0, 1'b0);
      check("bp_acc1", 32'(accepted), 32'd1);
      step(1'b1, 22'h234567, 11, 1'b1, 1'b0);
      check("bp_acc2", 32'(accepted), 32'd1);
      step(1'b1, 22'h345678, 12, 1'b0, 1'b0);
      check("bp_ready_low", 32'(in_ready_o), 32'd0);
      step(1'b1, 22'h345678, 12, 1'b0, 1'b0);
      check("bp_hold_ready_low", 32'(in_ready_o), 32'd0);
      step(1'b1, 22'h345678, 12, 1'b0, 1'b1);
      check("bp_release_accept", 32'(accepted), 32'd1);
      step(1'b0, 22'd0, 0, 1'b0, 1'b1);
      check("bp_stream2", 32'(out_valid_o), 32'd1);
      step(1'b0, 22'd0, 0, 1'b0, 1'b1);
      check("bp_stream3", 32'(out_valid_o), 32'd1);
      drain();

      // reset with two results in flight
      step(1'b1, 22'h180000, 14, 1'b0, 1'b0);
      step(1'b1, 22'h1C0000, 16, 1'b1, 1'b0);
      step(1'b0, 22'd0, 0, 1'b0, 1'b0);
      check("flight_valid", 32'(out_valid_o), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      #1;
      check("midrst_out_valid", 32'(out_valid_o), 32'd0);
      check("midrst_in_ready", 32'(in_ready_o), 32'd1);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 22'd0, 0, 1'b0, 1'b1);
         check("midrst_no_stale", 32'(out_valid_o), 32'd0);
      end

      // randomised traffic with random stalls
      for (int i = 0; i < 3000; i++) begin
         a  = int'($urandom_range(1024, 2047));
         b  = int'($urandom_range(1024, 2047));
         p  = 22'(a * b);
         if ($urandom_range(0, 15) == 0) p = '0;
         else if ($urandom_range(0, 15) == 0) p = 22'($urandom);
         es = int'($urandom_range(0, 62)) - 15;
         step($urandom_range(0, 3) != 0, p, es, 1'($urandom), $urandom_range(0, 3) != 0);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
